// File: rtl/single_port_ram_controller.sv
// single_port_ram_controller: arbitrates write and read requests onto one RAM port
// and returns read data through a one-entry response register.
//
// Parameters:
//   WIDTH          data word width
//   DEPTH          number of RAM words
//   READ_LATENCY   RAM read latency, 0 or 1
//   ADDRESS_WIDTH  address width
// Ports:
//   clock, reset                  single clock, synchronous active-high reset
//   write_valid/ready/address/data          write request channel
//   read_request_valid/ready, read_address  read request channel
//   read_response_valid/ready/data          read response channel
//   memory_*                      single read-write RAM port
module single_port_ram_controller #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int READ_LATENCY  = 1,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write_valid,
    output logic                     write_ready,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [WIDTH-1:0]         write_data,
    input  logic                     read_request_valid,
    output logic                     read_request_ready,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic                     read_response_valid,
    input  logic                     read_response_ready,
    output logic [WIDTH-1:0]         read_response_data,
    output logic                     memory_access_enable,
    output logic                     memory_write,
    output logic [ADDRESS_WIDTH-1:0] memory_address,
    output logic [WIDTH-1:0]         memory_write_data,
    input  logic [WIDTH-1:0]         memory_read_data
);
    typedef enum logic {IDLE, READ_PENDING} state_t;
    state_t state, state_next;
    logic prio_write, resp_valid, read_slot, contend, grant_write, grant_read, load;
    logic [WIDTH-1:0] resp_data;
    always_comb begin
        // a read may start only when idle and the response register frees up this cycle
        read_slot            = state == IDLE && (!resp_valid || read_response_ready);
        contend              = write_valid && read_request_valid && read_slot;
        write_ready          = !reset && (!contend || prio_write);
        read_request_ready   = !reset && read_slot && (!contend || !prio_write);
        grant_write          = write_valid && write_ready;
        grant_read           = read_request_valid && read_request_ready;
        memory_access_enable = grant_write || grant_read;
        memory_write         = grant_write;
        memory_address       = grant_write ? write_address : read_address;
        memory_write_data    = write_data;
        load                 = READ_LATENCY == 1 ? state == READ_PENDING : grant_read;
        state_next           = (READ_LATENCY == 1 && grant_read) ? READ_PENDING : IDLE;
    end
    assign read_response_valid = resp_valid && !reset;
    assign read_response_data  = resp_data;
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            prio_write <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            state <= state_next;
            // favour the class that was not granted most recently
            if (grant_write || grant_read)
                prio_write <= grant_read;
            if (load) begin
                resp_valid <= 1'b1;
                resp_data  <= memory_read_data;
            end else if (resp_valid && read_response_ready)
                resp_valid <= 1'b0;
        end
    end
endmodule

// File: doc/single_port_ram_controller.md
SINGLE_PORT_RAM_CONTROLLER -- requirements
Module: single_port_ram_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: number of words in the attached RAM.
REQ-003 SHALL have parameter READ_LATENCY, default 1: attached RAM read latency; only 0 and 1 are legal.
REQ-004 SHALL have parameter ADDRESS_WIDTH, default CLOG2(DEPTH): address width.
REQ-005 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port write_valid  input  1  write request present.
REQ-008 SHALL have port write_ready  output  1  write request accepted this cycle when high with write_valid.
REQ-009 SHALL have port write_address  input  ADDRESS_WIDTH  write target.
REQ-010 SHALL have port write_data  input  WIDTH  write payload.
REQ-011 SHALL have port read_request_valid  input  1  read request present.
REQ-012 SHALL have port read_request_ready  output  1  read request accepted this cycle when high with read_request_valid.
REQ-013 SHALL have port read_address  input  ADDRESS_WIDTH  read target.
REQ-014 SHALL have port read_response_valid  output  1  read_response_data valid.
REQ-015 SHALL have port read_response_ready  input  1  consumer takes the response.
REQ-016 SHALL have port read_response_data  output  WIDTH  returned read word.
REQ-017 SHALL have ports memory_access_enable (output, 1), memory_write (output, 1), memory_address (output, ADDRESS_WIDTH), memory_write_data (output, WIDTH), memory_read_data (input, WIDTH): single read-write port to the RAM.

Function
REQ-018 SHALL issue at most one RAM access per cycle; memory_access_enable high only in the cycle a request is accepted.
REQ-019 SHALL drive memory_write=1, memory_address=write_address, memory_write_data=write_data on an accepted write; memory_write=0, memory_address=read_address on an accepted read.
REQ-020 SHALL implement state machine IDLE / READ_PENDING; READ_PENDING is used only when READ_LATENCY=1.
REQ-021 SHALL, in IDLE with READ_LATENCY=1, go to READ_PENDING on an accepted read; READ_PENDING SHALL return to IDLE unconditionally after one cycle, loading memory_read_data into the response register.
REQ-022 SHALL, with READ_LATENCY=0, load memory_read_data into the response register at the end of the acceptance cycle and stay in IDLE.
REQ-023 SHALL hold a one-entry response register; read_response_valid set when loaded, cleared when read_response_valid and read_response_ready are both high with no same-cycle load.
REQ-024 SHALL keep read_response_data stable while read_response_valid is high and read_response_ready is low.
REQ-025 SHALL assert read_request_ready only in IDLE and when the response register is empty or being drained this cycle.
REQ-026 SHALL allow write acceptance in IDLE and in READ_PENDING (port is free in READ_PENDING).
REQ-027 SHALL arbitrate when both a write and a read are eligible in the same cycle by round-robin: grant the class not granted last in a contended cycle; a priority register resets to favour write.
REQ-028 SHALL keep ready outputs combinational from valids, state and priority; no combinational path from read_response_ready to memory outputs except via read_request_ready.
REQ-029 SHALL guarantee ordering: a read accepted after a write to the same address returns the new data.
REQ-030 SHALL ignore address bounds beyond DEPTH (no checking); values pass through unmodified.

Reset
REQ-031 SHALL, while reset is high, drive write_ready=0, read_request_ready=0, memory_access_enable=0, read_response_valid=0; state to IDLE; priority to write; response data to 0.
REQ-032 SHALL discard any in-flight read when reset asserts mid-operation; no response is produced for it.

Verification
REQ-033 SHALL verify: write addr 3 data 0xA5, then read addr 3 (LATENCY=1) -> read_response_valid high 2 cycles after read acceptance, data 0xA5.
REQ-034 SHALL verify: write and read both valid for 4 cycles to different addresses -> grants alternate W,R,W,R; memory_access_enable high each accepted cycle.
REQ-035 SHALL verify: read_response_ready held low with response 0x3C pending -> read_request_ready low, data held at 0x3C; raising ready drains it and a new read is accepted that cycle.
REQ-036 SHALL verify: read accepted (LATENCY=1) then write valid next cycle -> write accepted in READ_PENDING, read response unaffected.
REQ-037 SHALL verify: reset asserted in READ_PENDING -> next cycle read_response_valid=0, state IDLE, no response emitted.
REQ-038 SHALL verify: LATENCY=0, read addr 7 holding 0x11 -> read_response_valid high 1 cycle after acceptance with data 0x11.
